// File: rtl/data_set_writer_if.sv
// Sample-capture / serial-readout bundle for data_set_writer.
// Latency: none, wires only.
// Backpressure: in_ready gates sample producers; out_ready stalls the word stream.
interface data_set_writer_if #(
    parameter int W = 7
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x1;
    logic [W-1:0] in_x2;
    logic [1:0]   in_t;
    logic         start_dump;
    logic         clear;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_word;
    logic [7:0]   count;
    logic         full;
    logic         done;

    // Sample/command source and word sink side.
    modport master (
        output in_valid, in_x1, in_x2, in_t, start_dump, clear, out_ready,
        input  in_ready, out_valid, out_word, count, full, done
    );

    // Capture block side.
    modport slave (
        input  in_valid, in_x1, in_x2, in_t, start_dump, clear, out_ready,
        output in_ready, out_valid, out_word, count, full, done
    );
endinterface

// File: rtl/data_set_writer.sv
// Stores up to N_SAMPLES (x1, x2, t) samples interleaved, then streams them out one word per beat.
// Latency: sample stored on its accept edge; first word valid the cycle after start_dump is sampled.
// Backpressure: in_ready low when full or not filling; out_ready low holds out_word and rd_ptr.
module data_set_writer #(
    parameter int N_SAMPLES = 200,
    parameter int W         = 7
) (
    input  logic              clk,
    input  logic              rst,
    data_set_writer_if.slave  bus
);

    // Three words per sample; count is an 8-bit port, so N_SAMPLES must stay <= 255.
    localparam int DEPTH = 3 * N_SAMPLES;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [7:0]    count;
    logic [7:0]    count_n;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_n;
    logic          wr_en;
    logic          accept;
    logic          in_ready;
    logic [AW-1:0] wr_base;
    logic [AW-1:0] last_ptr;
    logic [W-1:0]  t_ext;

    // Sample storage; deliberately not reset, only words below 3*count are ever read.
    logic [W-1:0]  mem [DEPTH];

    // Base word of the slot the next sample lands in, and the index of the final stored word.
    assign wr_base  = AW'(32'(count) * 32'd3);
    assign last_ptr = AW'(32'(count) * 32'd3 - 32'd1);

    // Label is a 2-bit signed value; widen so -1 reads back as all ones.
    assign t_ext = {{(W-2){bus.in_t[1]}}, bus.in_t};

    assign in_ready = (state == FILL) && (count < 8'(N_SAMPLES));
    assign accept   = bus.in_valid && in_ready;

    // Next-state, counter and read-pointer decode; clear overrides every other request.
    always_comb begin
        state_n  = state;
        count_n  = count;
        rd_ptr_n = rd_ptr;
        wr_en    = 1'b0;
        if (bus.clear) begin
            state_n  = FILL;
            count_n  = '0;
            rd_ptr_n = '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        wr_en   = 1'b1;
                        count_n = count + 8'd1;
                    end
                    // A sample accepted on the same edge counts toward a non-empty buffer.
                    if (bus.start_dump && ((count != 8'd0) || accept)) begin
                        state_n  = DUMP;
                        rd_ptr_n = '0;
                    end
                end
                DUMP: begin
                    if (bus.out_ready) begin
                        rd_ptr_n = rd_ptr + AW'(1);
                        if (rd_ptr == last_ptr) begin
                            state_n = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.start_dump) begin
                        state_n  = DUMP;
                        rd_ptr_n = '0;
                    end
                end
                default: begin
                    state_n  = FILL;
                    count_n  = '0;
                    rd_ptr_n = '0;
                end
            endcase
        end
    end

    // State, sample counter and read pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FILL;
            count  <= '0;
            rd_ptr <= '0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            rd_ptr <= rd_ptr_n;
        end
    end

    // All three words of an accepted sample are written on one edge.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_base]          <= bus.in_x1;
            mem[wr_base + AW'(1)] <= bus.in_x2;
            mem[wr_base + AW'(2)] <= t_ext;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == DUMP);
    assign bus.out_word  = (state == DUMP) ? mem[rd_ptr] : '0;
    assign bus.count     = count;
    assign bus.full      = (count == 8'(N_SAMPLES));
    assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_data_set_writer.sv
// Directed bench for data_set_writer with a queue-based reference model checked every cycle.
// Latency: model advances on each rising edge; outputs compared on the falling edge.
// Backpressure: out_ready patterns driven directly by the stimulus.
module tb_data_set_writer;
    localparam int N = 200;
    localparam int W = 7;
    localparam int M_FILL = 0;
    localparam int M_EMIT = 1;
    localparam int M_FIN  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_set_writer_if #(.W(W)) bus();

    data_set_writer #(.N_SAMPLES(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: stored samples as plain integers, plus where the stream is.
    int mx1[$];
    int mx2[$];
    int mt[$];
    int m_mode = M_FILL;
    int m_idx  = 0;
    bit chk_en = 1'b0;

    int cap[$];
    int cap_cyc[$];
    int exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
        end
    endtask

    function automatic logic [W-1:0] m_word(input int idx);
        int k;
        int v;
        k = idx / 3;
        case (idx % 3)
            0:       v = mx1[k];
            1:       v = mx2[k];
            default: v = mt[k];
        endcase
        return W'(v);
    endfunction

    always @(posedge clk) cyc++;

    // Model update from the inputs present at this edge.
    always @(posedge clk) begin
        if (rst || bus.clear) begin
            mx1.delete(); mx2.delete(); mt.delete();
            m_mode = M_FILL;
            m_idx  = 0;
            if (rst) chk_en = 1'b1;
        end else begin
            case (m_mode)
                M_FILL: begin
                    if (bus.in_valid && mx1.size() < N) begin
                        mx1.push_back(int'($signed(bus.in_x1)));
                        mx2.push_back(int'($signed(bus.in_x2)));
                        mt.push_back(int'($signed(bus.in_t)));
                    end
                    if (bus.start_dump && mx1.size() > 0) begin
                        m_mode = M_EMIT;
                        m_idx  = 0;
                    end
                end
                M_EMIT: begin
                    if (bus.out_ready) begin
                        m_idx++;
                        if (m_idx == 3 * mx1.size()) m_mode = M_FIN;
                    end
                end
                default: begin
                    if (bus.start_dump) begin
                        m_mode = M_EMIT;
                        m_idx  = 0;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(bus.out_valid), 32'(m_mode == M_EMIT));
            chk("out_word", 32'(bus.out_word), (m_mode == M_EMIT) ? 32'(m_word(m_idx)) : 32'd0);
            chk("count", 32'(bus.count), 32'(mx1.size()));
            chk("full", 32'(bus.full), 32'(mx1.size() == N));
            chk("in_ready", 32'(bus.in_ready), 32'(m_mode == M_FILL && mx1.size() < N));
            chk("done", 32'(bus.done), 32'(m_mode == M_FIN));
        end
    end

    // Record transferred words for the literal sequence checks.
    always @(negedge clk) begin
        if (chk_en && !rst && !bus.clear && bus.out_valid && bus.out_ready) begin
            cap.push_back(int'($signed(bus.out_word)));
            cap_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int b, input int t);
        bus.in_valid = 1'b1;
        bus.in_x1    = W'(a);
        bus.in_x2    = W'(b);
        bus.in_t     = 2'(t);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_dump();
        bus.start_dump = 1'b1;
        step();
        bus.start_dump = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(bus.done), 32'd1);
    endtask

    task automatic chk_seq(input string name, input int e[$]);
        chk({name, "_len"}, cap.size(), e.size());
        for (int i = 0; i < e.size() && i < cap.size(); i++) chk(name, cap[i], e[i]);
    endtask

    initial begin
        int t0;
        int pat[5];
        bus.in_valid   = 1'b0;
        bus.in_x1      = '0;
        bus.in_x2      = '0;
        bus.in_t       = '0;
        bus.start_dump = 1'b0;
        bus.clear      = 1'b0;
        bus.out_ready  = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_full", 32'(bus.full), 0);

        // Two samples, free-flowing dump.
        wr(5, -3, 1);
        wr(-64, 63, -1);
        bus.out_ready = 1'b1;
        cap.delete(); cap_cyc.delete();
        pulse_dump();
        t0 = cyc;
        wait_done("basic_done", 20);
        exp_q = '{5, -3, 1, -64, 63, -1};
        chk_seq("basic_word", exp_q);
        if (cap_cyc.size() == 6) begin
            chk("basic_first_cycle", cap_cyc[0], t0);
            chk("basic_consecutive", cap_cyc[5] - cap_cyc[0], 5);
        end
        chk("done_word_zero", 32'(bus.out_word), 0);

        // Replay from DONE.
        cap.delete(); cap_cyc.delete();
        pulse_dump();
        wait_done("replay_done", 20);
        chk_seq("replay_word", exp_q);

        // Empty dump request ignored, then accept coincident with start_dump.
        pulse_clear();
        chk("clear_count", 32'(bus.count), 0);
        pulse_dump();
        chk("empty_dump_valid", 32'(bus.out_valid), 0);
        chk("empty_dump_ready", 32'(bus.in_ready), 1);
        step();
        chk("empty_dump_valid2", 32'(bus.out_valid), 0);
        wr(1, 2, 0);
        cap.delete(); cap_cyc.delete();
        bus.in_valid = 1'b1;
        bus.in_x1 = W'(3);
        bus.in_x2 = W'(-4);
        bus.in_t  = 2'(-1);
        pulse_dump();
        bus.in_valid = 1'b0;
        wait_done("coincident_done", 20);
        exp_q = '{1, 2, 0, 3, -4, -1};
        chk_seq("coincident_word", exp_q);
        chk("coincident_count", 32'(bus.count), 2);

        // Stalled dump of a single sample.
        pulse_clear();
        wr(7, -7, 1);
        bus.out_ready = 1'b0;
        cap.delete(); cap_cyc.delete();
        pulse_dump();
        pat = '{1, 0, 0, 1, 1};
        for (int i = 0; i < 5; i++) begin
            bus.out_ready = pat[i][0];
            step();
            if (i == 1 || i == 2) chk("stall_hold", int'($signed(bus.out_word)), -7);
        end
        chk("stall_done", 32'(bus.done), 1);
        exp_q = '{7, -7, 1};
        chk_seq("stall_word", exp_q);

        // Clear in the middle of a dump.
        pulse_clear();
        wr(10, 11, 1);
        wr(12, 13, 0);
        bus.out_ready = 1'b1;
        cap.delete(); cap_cyc.delete();
        pulse_dump();
        step();
        bus.out_ready = 1'b0;
        pulse_clear();
        chk("clr_mid_valid", 32'(bus.out_valid), 0);
        chk("clr_mid_count", 32'(bus.count), 0);
        chk("clr_mid_ready", 32'(bus.in_ready), 1);
        chk("clr_mid_words", cap.size(), 1);

        // Reset in the middle of a dump.
        wr(20, 21, -1);
        bus.out_ready = 1'b1;
        cap.delete(); cap_cyc.delete();
        pulse_dump();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_valid", 32'(bus.out_valid), 0);
        chk("rst_mid_count", 32'(bus.count), 0);
        chk("rst_mid_ready", 32'(bus.in_ready), 1);
        step();
        step();
        chk("rst_mid_words", cap.size(), 1);

        // Fill to capacity, overflow attempt, full dump.
        for (int i = 0; i < N; i++) wr((i * 5) % 128 - 64, 63 - (i % 128), (i % 3) - 1);
        chk("cap_count", 32'(bus.count), 200);
        chk("cap_full", 32'(bus.full), 1);
        chk("cap_in_ready", 32'(bus.in_ready), 0);
        wr(1, 1, 1);
        chk("overflow_count", 32'(bus.count), 200);
        cap.delete(); cap_cyc.delete();
        bus.out_ready = 1'b1;
        pulse_dump();
        wait_done("cap_done", 700);
        chk("cap_words", cap.size(), 600);
        if (cap.size() == 600) begin
            chk("cap_w0", cap[0], -64);
            chk("cap_w1", cap[1], 63);
            chk("cap_w2", cap[2], -1);
            chk("cap_w597", cap[597], 35);
            chk("cap_w598", cap[598], -8);
            chk("cap_w599", cap[599], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/data_set_writer.md
DATA_SET_WRITER -- requirements
Module: data_set_writer

Interface
REQ-001 The module SHALL have parameter N_SAMPLES, default 200, giving the maximum number of (x1, x2, t) samples stored.
REQ-002 The module SHALL have parameter W, default 7, giving the stored word width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  an input sample is presented.
REQ-006 in_ready  output  1  the block accepts a sample this cycle.
REQ-007 in_x1  input  W  first feature, signed.
REQ-008 in_x2  input  W  second feature, signed.
REQ-009 in_t  input  2  target label, signed; legal values -1, 0, +1.
REQ-010 start_dump  input  1  single-cycle request to begin serial readout.
REQ-011 clear  input  1  single-cycle request to discard stored samples.
REQ-012 out_valid  output  1  out_word holds a valid word.
REQ-013 out_ready  input  1  downstream accepts out_word.
REQ-014 out_word  output  W  serialized word, signed.
REQ-015 count  output  8  number of samples stored, 0..N_SAMPLES.
REQ-016 full  output  1  count == N_SAMPLES.
REQ-017 done  output  1  high while in state DONE.

Function
REQ-018 The block SHALL contain a 3*N_SAMPLES x W buffer with the interleaved layout x1, x2, t: word 3k = x1, word 3k+1 = x2, word 3k+2 = t of sample k.
REQ-019 The FSM SHALL have exactly three states: FILL, DUMP and DONE.
REQ-020 In FILL, in_ready SHALL equal (count < N_SAMPLES); in DUMP and DONE, in_ready SHALL be 0.
REQ-021 On an accept (in_valid && in_ready), the block SHALL write x1, x2 and sign-extended t to words 3*count, 3*count+1 and 3*count+2 in the same edge, and SHALL increment count by 1.
REQ-022 The t field SHALL be stored sign-extended to W bits: -1 -> all ones, 0 -> 0, +1 -> 1.
REQ-023 Assertion of in_valid while full is high SHALL be ignored, with no write and no change to count.
REQ-024 In FILL, start_dump with count > 0 SHALL move the FSM to DUMP and set the read pointer to 0.
REQ-025 In FILL, start_dump with count == 0 SHALL be ignored.
REQ-026 An accept coincident with start_dump SHALL be stored first; the dump SHALL then cover count+1 samples.
REQ-027 In DUMP, out_valid SHALL be 1 and out_word SHALL equal buffer[rd_ptr]; the first word SHALL be valid in the cycle after start_dump is sampled.
REQ-028 While out_valid && !out_ready, out_word and rd_ptr SHALL hold stable.
REQ-029 On each out_valid && out_ready handshake, rd_ptr SHALL increment by 1.
REQ-030 The handshake on word 3*count-1 SHALL move the FSM to DONE; exactly 3*count words SHALL be emitted per dump.
REQ-031 In DONE, out_valid SHALL be 0 and done SHALL be 1; the buffer and count SHALL be retained.
REQ-032 In DONE, start_dump SHALL re-enter DUMP with rd_ptr = 0, replaying the identical word sequence.
REQ-033 clear in any state SHALL set count = 0 and rd_ptr = 0 and move the FSM to FILL on the next edge.
REQ-034 A clear during DUMP SHALL abort the dump, with out_valid deasserted from the next cycle.
REQ-035 clear SHALL take priority over start_dump and over any input accept in the same cycle.
REQ-036 In every state except DUMP, out_word SHALL be 0.

Reset
REQ-037 While rst is high at a clock edge, the FSM SHALL enter FILL, and count and rd_ptr SHALL be 0.
REQ-038 While rst is high at a clock edge, out_valid, done and full SHALL be 0, and in_ready SHALL be 1 in the following cycle.
REQ-039 Buffer contents SHALL NOT be reset; unwritten words are never emitted.
REQ-040 rst SHALL take priority over clear, start_dump and all handshakes.
REQ-041 A reset mid-dump SHALL abort the dump with no further words emitted.

Verification
REQ-042 Write 2 samples (5, -3, +1) and (-64, 63, -1), then start_dump with out_ready = 1 -> words 5, -3, 1, -64, 63, -1 on 6 consecutive cycles, then done = 1.
REQ-043 Write 200 samples -> full = 1 and in_ready = 0; a 201st in_valid is ignored and count stays 200; the dump emits 600 words.
REQ-044 Dump 1 sample with out_ready toggling 1,0,0,1,1 -> out_word holds during stalls and exactly 3 words are transferred.
REQ-045 start_dump with count = 0 -> state stays FILL and out_valid stays 0; an accept coincident with start_dump on count = 1 -> 6 words emitted.
REQ-046 In DONE, start_dump -> identical sequence replayed; clear mid-dump, or rst mid-dump, -> out_valid = 0 next cycle, count = 0, in_ready = 1.
